// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures one byte per rising edge of the receiver's done level, stores it
// in a circular buffer and returns it through a registered read handshake.
// A byte arriving while the buffer is full is dropped and flagged in a
// sticky overflow bit.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK100MHZ,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  input  logic                  rd_en,
  input  logic                  clr_ovf,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Count value that means "every slot occupied".
  logic [DEPTH_LOG2:0] full_cnt;
  assign full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic                  done_q;
  logic                  empty_q;
  logic                  full_q;
  logic                  ovf_q;
  logic [7:0]            rd_data_q;
  logic                  rd_valid_q;

  logic wr_stb;
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;

  // A read frees a slot in the same cycle, so a write into a full buffer
  // is still accepted when it coincides with an accepted read.
  assign wr_stb  = rx_done & ~done_q;
  assign rd_acc  = rd_en & ~empty_q;
  assign wr_acc  = wr_stb & (~full_q | rd_acc);
  assign wr_drop = wr_stb & full_q & ~rd_acc;

  // Next occupancy: +1 write only, -1 read only, unchanged otherwise.
  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array: written without reset since contents are don't-care.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= rx_data;
    end
  end

  // Edge detector, pointers, occupancy flags and the registered read port.
  // done_q resets high so a done level held across reset is not captured.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      done_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      done_q     <= rx_done;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      full_q     <= (count_d == full_cnt);
      rd_valid_q <= rd_acc;
      if (wr_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_acc) begin
        rd_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (wr_drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for short handshake
// sequences plus hand-written fill/overflow/wrap/reset sequences.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_en;
  logic       clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rd_en     (rd_en),
    .clr_ovf   (clr_ovf),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [7:0] e_data;
    logic       e_valid;
    logic [4:0] e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_data, input logic e_valid,
                         input logic [4:0] e_count, input logic e_empty,
                         input logic e_full, input logic e_ovf);
    chk({tag, ".rd_data"},  32'(rd_data),  32'(e_data));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(e_valid));
    chk({tag, ".count"},    32'(count),    32'(e_count));
    chk({tag, ".empty"},    32'(empty),    32'(e_empty));
    chk({tag, ".full"},     32'(full),     32'(e_full));
    chk({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    step();
    rx_done = 1'b0;
    step();
  endtask

  initial begin
    // done data rd clr | e_data valid count empty full ovf
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'hA5, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h44, 1'b0, 1'b0, 8'hA5, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b0, 8'h5A, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 8'h77, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h88, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h88, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};

    reset   = 1'b1;
    rx_data = 8'h00;
    rx_done = 1'b1;
    rd_en   = 1'b0;
    clr_ovf = 1'b0;

    // Reset held 100 cycles with done high throughout.
    repeat (100) step();
    chk_all("reset", 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    $display("txn reset-hold: count=%0d empty=%0b", count, empty);
    reset = 1'b0;
    step();
    step();
    chk_all("post_reset_done_high", 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    $display("txn reset-release with done high: count=%0d", count);
    rx_done = 1'b0;
    step();

    // Table-driven short sequences.
    for (int i = 0; i < 15; i++) begin
      rx_done = vecs[i].done;
      rx_data = vecs[i].data;
      rd_en   = vecs[i].rd;
      clr_ovf = vecs[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_valid, vecs[i].e_count,
              vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf);
      $display("txn vec%0d: done=%0b rd=%0b -> rd_data=%02h valid=%0b count=%0d",
               i, vecs[i].done, vecs[i].rd, rd_data, rd_valid, count);
    end
    rd_en   = 1'b0;
    clr_ovf = 1'b0;

    // Fill to full.
    for (int i = 0; i < 16; i++) wr_byte(8'(i));
    chk_all("fill", 8'h88, 1'b0, 5'd16, 1'b0, 1'b1, 1'b0);
    $display("txn fill 00..0F: count=%0d full=%0b", count, full);

    // Write while full: dropped, overflow set on the next edge.
    rx_done = 1'b1;
    rx_data = 8'h10;
    step();
    chk_all("drop", 8'h88, 1'b0, 5'd16, 1'b0, 1'b1, 1'b1);
    $display("txn write 10 while full: overflow=%0b count=%0d", overflow, count);
    rx_done = 1'b0;
    step();

    // Clear coinciding with a drop: set wins; then clear alone.
    rx_done = 1'b1;
    rx_data = 8'h99;
    clr_ovf = 1'b1;
    step();
    chk("clr_vs_drop.overflow", 32'(overflow), 32'd1);
    rx_done = 1'b0;
    step();
    chk("clr.overflow", 32'(overflow), 32'd0);
    chk("clr.count", 32'(count), 32'd16);
    $display("txn clr_ovf: overflow=%0b", overflow);
    clr_ovf = 1'b0;

    // Simultaneous write and read while full.
    rx_done = 1'b1;
    rx_data = 8'hEE;
    rd_en   = 1'b1;
    step();
    chk_all("simul", 8'h00, 1'b1, 5'd16, 1'b0, 1'b1, 1'b0);
    $display("txn simultaneous wr EE/rd: rd_data=%02h count=%0d", rd_data, count);
    rx_done = 1'b0;
    rd_en   = 1'b0;
    step();
    chk("simul.valid_pulse", 32'(rd_valid), 32'd0);

    // Drain in order: 01..0F then EE.
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] e;
      e = (i == 16) ? 8'hEE : 8'(i);
      step();
      chk($sformatf("drain%0d.data", i), 32'(rd_data), 32'(e));
      chk($sformatf("drain%0d.valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(16 - i));
      $display("txn drain: rd_data=%02h count=%0d", rd_data, count);
    end
    rd_en = 1'b0;
    step();
    chk_all("drained", 8'hEE, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);

    // Two refill/drain rounds so the pointers cross the wrap point.
    for (int r = 0; r < 2; r++) begin
      logic [7:0] base;
      base = (r == 0) ? 8'h20 : 8'h30;
      for (int i = 0; i < 8; i++) wr_byte(base + 8'(i));
      chk($sformatf("refill%0d.count", r), 32'(count), 32'd8);
      rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
        step();
        chk($sformatf("wrap%0d_%0d.data", r, i), 32'(rd_data), 32'(base + 8'(i)));
        chk($sformatf("wrap%0d_%0d.valid", r, i), 32'(rd_valid), 32'd1);
        $display("txn wrap read: rd_data=%02h count=%0d", rd_data, count);
      end
      rd_en = 1'b0;
      step();
    end

    // Read requests while empty are ignored.
    rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("empty_rd%0d", i), 8'h37, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    end
    $display("txn empty read x10: rd_data=%02h valid=%0b", rd_data, rd_valid);
    rd_en = 1'b0;

    // Mid-stream reset: fill, overflow, drain to 5 left, reset during a read.
    for (int i = 0; i < 16; i++) wr_byte(8'h40 + 8'(i));
    wr_byte(8'hFF);
    chk("pre_rst.overflow", 32'(overflow), 32'd1);
    rd_en = 1'b1;
    repeat (11) step();
    chk("pre_rst.count", 32'(count), 32'd5);
    chk("pre_rst.data", 32'(rd_data), 32'h4A);
    step();
    chk("pre_rst.valid", 32'(rd_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    $display("txn mid-stream reset: count=%0d valid=%0b overflow=%0b", count, rd_valid, overflow);
    rd_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    wr_byte(8'h5C);
    chk("post_rst.count", 32'(count), 32'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk_all("post_rst_rd", 8'h5C, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    $display("txn post-reset byte: rd_data=%02h", rd_data);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
